fifo_rr_arbiter: RTL and testbench
==================================

Name: fifo_rr_arbiter

Overview:
Round-robin drain arbiter that merges up to N_CH show-ahead synchronous FIFOs into one valid/ready output stream. Each source exposes empty plus head-of-queue data and accepts a read enable. A per-channel burst limit bounds consecutive grants to one source. A single output register holds the data and decouples downstream backpressure from the FIFO read path.

Parameters:
N_CH, 4, number of source FIFOs (>= 2)
WIDTH, 32, data width per source
MAX_BURST, 4, max consecutive grants to one channel before forced rotation (>= 1; 1 = pure round-robin)
W_CH, $clog2(N_CH), width of channel index
W_BURST, $clog2(MAX_BURST + 1), width of burst counter

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
chan_en  input  N_CH  per-channel enable; 0 masks the channel from arbitration
src_empty  input  N_CH  per-source FIFO empty flag
src_r_data  input  N_CH*WIDTH  head-of-queue data, channel i at bits [i*WIDTH +: WIDTH], valid when !src_empty[i]
src_r_en  output  N_CH  pop strobe to source FIFOs, at most one bit set
out_valid  output  1  output register holds data
out_ready  input  1  downstream accepts output this cycle
out_data  output  WIDTH  granted data
out_ch  output  W_CH  channel index out_data came from

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. All state clears immediately on rst assertion, independent of clk.
- Reset values: out_valid=0, out_data=0, out_ch=0, owner=N_CH-1, burst_cnt=MAX_BURST (exhausted). The first grant after reset therefore searches from ch0.
- req[i] = chan_en[i] && !src_empty[i].
- load = !out_valid || out_ready. The output register may refill in the same cycle it is consumed, giving 1 word/cycle sustained throughput.
- src_r_en is combinational from req, load, owner and burst_cnt. No registered path. It is zero whenever !load or req==0.
- Grant rule, evaluated when load=1:
  - Keep case: req[owner] && burst_cnt < MAX_BURST. Grant owner; burst_cnt <= burst_cnt+1.
  - Rotate case: otherwise, grant the first set bit of req searching owner+1, owner+2, ..., wrapping mod N_CH, with owner itself checked last. Set owner <= grant and burst_cnt <= 1.
  - Release case: req[owner]==0 with no grant possible (req==0). Set burst_cnt <= MAX_BURST; owner is unchanged.
- On grant g: src_r_en[g]=1 this cycle. At the clock edge, out_data <= src_r_data[g], out_ch <= g, out_valid <= 1. Latency from pop to out_valid is 1 cycle.
- When load=1 and no grant: out_valid <= 0.
- When load=0 (out_valid && !out_ready): out_data, out_ch and out_valid hold; no pops; owner and burst_cnt hold.
- chan_en deasserted for the owner mid-burst: treated as not requesting. Ownership is released, or rotation occurs, in the same cycle.
- Never pops an empty or disabled source. src_r_en is one-hot-or-zero every cycle.
- Reset mid-stream: the output word is discarded. Source FIFOs are not affected by this block.
- Wrap-around: channel index arithmetic is mod N_CH. For N_CH that is not a power of 2, an index never reaches N_CH.
- Simulation-only checks:
  - Warn if src_r_en is not one-hot-or-zero.
  - Warn if src_r_en[i] is set while src_empty[i] is set.

Test Plan:
1. Reset release, all src_empty=1, out_ready=1 → out_valid=0 and src_r_en=0 for 10 cycles.
2. N_CH=4, MAX_BURST=2, chan_en=4'hF, each source holds 3 words, out_ready=1 → out_ch sequence 0,0,1,1,2,2,3,3,0,1,2,3 on 12 consecutive cycles with no bubbles. Then out_valid=0.
3. Continuous traffic, out_ready=0 for 5 cycles while out_valid=1 → out_data and out_ch stable, src_r_en=0 all 5 cycles. Output resumes with the next word in sequence and no loss or duplication.
4. MAX_BURST=4, ch1 holds 1 word, ch2 holds 4 words, owner=ch0 with its FIFO empty → out_ch sequence 1,2,2,2,2. Ch1 empties after one grant and releases ownership early.
5. chan_en=4'b1010, all sources non-empty, MAX_BURST=1 → grants alternate 1,3,1,3. src_r_en[0] and src_r_en[2] never assert.
6. rst asserted asynchronously mid-burst, between clock edges → out_valid drops to 0 before the next clk edge. After release with all sources full, the first grant is ch0.

Source files
------------

// File: rtl/fifo_rr_arbiter_if.sv
// Bundle between the source FIFOs, the drain arbiter and the downstream consumer.
// master = arbiter side, slave = the environment that owns the FIFOs and the sink.
interface fifo_rr_arbiter_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 32,
  parameter int W_CH  = $clog2(N_CH)
);
  logic [N_CH-1:0]       chan_en;
  logic [N_CH-1:0]       src_empty;
  logic [N_CH*WIDTH-1:0] src_r_data;
  logic [N_CH-1:0]       src_r_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [W_CH-1:0]       out_ch;

  modport master (
    input  chan_en, src_empty, src_r_data, out_ready,
    output src_r_en, out_valid, out_data, out_ch
  );

  modport slave (
    output chan_en, src_empty, src_r_data, out_ready,
    input  src_r_en, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain arbiter: merges N_CH show-ahead FIFOs into one valid/ready stream,
// bounding consecutive grants per channel and buffering the word in one output register.
module fifo_rr_arbiter #(
  parameter int N_CH      = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4,
  parameter int W_CH      = $clog2(N_CH),
  parameter int W_BURST   = $clog2(MAX_BURST + 1)
) (
  input logic               clk,
  input logic               rst,
  fifo_rr_arbiter_if.master bus
);

  localparam logic [W_BURST-1:0] BURST_FULL = W_BURST'(MAX_BURST);
  localparam logic [W_BURST-1:0] BURST_ONE  = W_BURST'(1);
  localparam logic [W_CH-1:0]    LAST_CH    = W_CH'(N_CH - 1);

  logic [N_CH-1:0]    req;
  logic               any_req;
  logic               load;
  logic               keep;
  logic               grant_valid;
  logic [W_CH-1:0]    rot_idx;
  logic [W_CH-1:0]    grant_idx;
  logic [WIDTH-1:0]   grant_data;
  logic [N_CH-1:0]    src_r_en;

  logic [W_CH-1:0]    owner;
  logic [W_BURST-1:0] burst_cnt;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [W_CH-1:0]    out_ch;

  assign req     = bus.chan_en & ~bus.src_empty;
  assign any_req = |req;
  assign load    = !out_valid || bus.out_ready;
  assign keep    = req[owner] && (burst_cnt < BURST_FULL);

  // Search starts just past the owner so the owner itself is the last candidate.
  always_comb begin
    int               idx;
    logic             found;
    logic [W_CH-1:0]  cand;
    found   = 1'b0;
    rot_idx = owner;
    idx     = 0;
    cand    = '0;
    for (int s = 1; s <= N_CH; s++) begin
      idx = int'(owner) + s;
      if (idx >= N_CH) idx = idx - N_CH;
      cand = W_CH'(idx);
      if (!found && req[cand]) begin
        found   = 1'b1;
        rot_idx = cand;
      end
    end
  end

  assign grant_idx   = keep ? owner : rot_idx;
  assign grant_valid = load && any_req && !rst;

  always_comb begin
    src_r_en   = '0;
    grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_idx == W_CH'(i)) begin
        grant_data  = bus.src_r_data[i*WIDTH +: WIDTH];
        src_r_en[i] = grant_valid;
      end
    end
  end

  // Owner and burst count only move when the output register can take a word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      owner     <= LAST_CH;
      burst_cnt <= BURST_FULL;
    end else if (load) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant_idx;
        owner     <= grant_idx;
        burst_cnt <= keep ? (burst_cnt + BURST_ONE) : BURST_ONE;
      end else begin
        out_valid <= 1'b0;
        burst_cnt <= BURST_FULL;
      end
    end
  end

  assign bus.src_r_en  = src_r_en;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_ch    = out_ch;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(src_r_en))
        else $warning("fifo_rr_arbiter: src_r_en not one-hot-or-zero: %b", src_r_en);
      assert ((src_r_en & bus.src_empty) == '0)
        else $warning("fifo_rr_arbiter: pop of empty source: en=%b empty=%b",
                      src_r_en, bus.src_empty);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: three instances (MAX_BURST 1, 2, 4) fed by modelled
// show-ahead FIFOs; directed scenarios plus a randomized run against a reference model.
module tb_fifo_rr_arbiter;
  localparam int N     = 4;
  localparam int W     = 32;
  localparam int NK    = 3;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rr_arbiter_if #(.N_CH(N), .WIDTH(W)) b0 ();
  fifo_rr_arbiter_if #(.N_CH(N), .WIDTH(W)) b1 ();
  fifo_rr_arbiter_if #(.N_CH(N), .WIDTH(W)) b2 ();

  fifo_rr_arbiter #(.N_CH(N), .WIDTH(W), .MAX_BURST(1)) u_mb1 (.clk(clk), .rst(rst), .bus(b0));
  fifo_rr_arbiter #(.N_CH(N), .WIDTH(W), .MAX_BURST(2)) u_mb2 (.clk(clk), .rst(rst), .bus(b1));
  fifo_rr_arbiter #(.N_CH(N), .WIDTH(W), .MAX_BURST(4)) u_mb4 (.clk(clk), .rst(rst), .bus(b2));

  logic [W-1:0] mem [NK][N][DEPTH];
  int           rdp [NK][N];
  int           wrp [NK][N];
  logic [N-1:0] en  [NK];
  logic         rdy [NK];
  logic [N-1:0] pe  [NK];

  logic [N-1:0] o_en [NK];
  logic         o_v  [NK];
  logic [W-1:0] o_d  [NK];
  logic [1:0]   o_ch [NK];

  int total = 0;
  int bad   = 0;

  function automatic int mb_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  function automatic logic [W-1:0] wv(int c, int j);
    return 32'h5A00_0000 + W'(c * 256 + j);
  endfunction

  function automatic logic [N-1:0] empt(int k);
    logic [N-1:0] e;
    for (int c = 0; c < N; c++) e[c] = (rdp[k][c] == wrp[k][c]);
    return e;
  endfunction

  function automatic logic [W-1:0] head(int k, int c);
    return mem[k][c][rdp[k][c] % DEPTH];
  endfunction

  function automatic logic [N*W-1:0] heads(int k);
    logic [N*W-1:0] v;
    for (int c = 0; c < N; c++) v[c*W +: W] = head(k, c);
    return v;
  endfunction

  task automatic drive();
    b0.chan_en = en[0]; b0.src_empty = empt(0); b0.src_r_data = heads(0); b0.out_ready = rdy[0];
    b1.chan_en = en[1]; b1.src_empty = empt(1); b1.src_r_data = heads(1); b1.out_ready = rdy[1];
    b2.chan_en = en[2]; b2.src_empty = empt(2); b2.src_r_data = heads(2); b2.out_ready = rdy[2];
  endtask

  task automatic snap();
    o_en[0] = b0.src_r_en; o_v[0] = b0.out_valid; o_d[0] = b0.out_data; o_ch[0] = b0.out_ch;
    o_en[1] = b1.src_r_en; o_v[1] = b1.out_valid; o_d[1] = b1.out_data; o_ch[1] = b1.out_ch;
    o_en[2] = b2.src_r_en; o_v[2] = b2.out_valid; o_d[2] = b2.out_data; o_ch[2] = b2.out_ch;
  endtask

  task automatic look();
    @(negedge clk);
    snap();
    for (int k = 0; k < NK; k++) pe[k] = o_en[k];
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    for (int k = 0; k < NK; k++) begin
      for (int c = 0; c < N; c++)
        if (pe[k][c] && rdp[k][c] < wrp[k][c]) rdp[k][c]++;
      pe[k] = '0;
    end
    drive();
  endtask

  task automatic push(int k, int c, logic [W-1:0] v);
    mem[k][c][wrp[k][c] % DEPTH] = v;
    wrp[k][c]++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < NK; k++) begin
      rdy[k] = 1'b1;
      en[k]  = '0;
      pe[k]  = '0;
      for (int c = 0; c < N; c++) begin
        rdp[k][c] = 0;
        wrp[k][c] = 0;
        mem[k][c][0] = '0;
      end
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < NK; k++) en[k] = 4'hF;
    drive();
    snap();
    for (int k = 0; k < NK; k++) begin
      total++;
      if (o_v[k] !== 1'b0 || o_d[k] !== '0 || o_ch[k] !== 2'd0) begin
        bad++;
        $display("FAIL reset_state k=%0d valid=%b data=%h ch=%0d required 0/0/0", k, o_v[k], o_d[k], o_ch[k]);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      look();
      for (int k = 0; k < NK; k++) begin
        total++;
        if (o_v[k] !== 1'b0) begin
          bad++;
          $display("FAIL idle_valid k=%0d cyc=%0d got=%b required=0", k, i, o_v[k]);
        end
        total++;
        if (o_en[k] !== 4'b0000) begin
          bad++;
          $display("FAIL idle_pop k=%0d cyc=%0d got=%b required=0000", k, i, o_en[k]);
        end
      end
      adv();
    end
  endtask

  task automatic test_burst_rotation();
    int seq [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
    int cnt [N]  = '{0, 0, 0, 0};
    int e;
    do_reset();
    en[1] = 4'hF;
    for (int c = 0; c < N; c++)
      for (int j = 0; j < 3; j++) push(1, c, wv(c, j));
    drive();
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      look();
      if (i >= 1 && i <= 12) begin
        e = seq[i-1];
        total++;
        if (o_v[1] !== 1'b1 || o_ch[1] !== 2'(e) || o_d[1] !== wv(e, cnt[e])) begin
          bad++;
          $display("FAIL burst_seq step=%0d got v=%b ch=%0d d=%h required v=1 ch=%0d d=%h",
                   i - 1, o_v[1], o_ch[1], o_d[1], e, wv(e, cnt[e]));
        end
        cnt[e]++;
      end else begin
        total++;
        if (o_v[1] !== 1'b0) begin
          bad++;
          $display("FAIL burst_edge cyc=%0d valid=%b required=0", i, o_v[1]);
        end
      end
      adv();
    end
  endtask

  task automatic test_backpressure();
    int exp_c [16];
    logic [W-1:0] exp_d [16];
    int got_c [32];
    logic [W-1:0] got_d [32];
    int n = 0;
    int idx = 0;
    do_reset();
    en[1] = 4'hF;
    for (int c = 0; c < N; c++)
      for (int j = 0; j < 4; j++) push(1, c, wv(c, j));
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < N; c++)
        for (int t = 0; t < 2; t++) begin
          exp_c[idx] = c;
          exp_d[idx] = wv(c, r * 2 + t);
          idx++;
        end
    drive();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      look();
      if (o_v[1] && rdy[1] && n < 32) begin
        got_c[n] = int'(o_ch[1]);
        got_d[n] = o_d[1];
        n++;
      end
      if (i >= 4 && i <= 8) begin
        total++;
        if (o_v[1] !== 1'b1 || o_ch[1] !== 2'(exp_c[3]) || o_d[1] !== exp_d[3]) begin
          bad++;
          $display("FAIL stall_hold cyc=%0d got v=%b ch=%0d d=%h required v=1 ch=%0d d=%h",
                   i, o_v[1], o_ch[1], o_d[1], exp_c[3], exp_d[3]);
        end
        total++;
        if (o_en[1] !== 4'b0000) begin
          bad++;
          $display("FAIL stall_pop cyc=%0d got=%b required=0000", i, o_en[1]);
        end
      end
      adv();
      if (i == 3) begin rdy[1] = 1'b0; drive(); end
      if (i == 8) begin rdy[1] = 1'b1; drive(); end
    end
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL stall_count got=%0d required=16", n);
    end
    for (int j = 0; j < 16 && j < n; j++) begin
      total++;
      if (got_c[j] != exp_c[j] || got_d[j] !== exp_d[j]) begin
        bad++;
        $display("FAIL stall_order idx=%0d got ch=%0d d=%h required ch=%0d d=%h",
                 j, got_c[j], got_d[j], exp_c[j], exp_d[j]);
      end
    end
  endtask

  task automatic test_early_release();
    int seq [6] = '{0, 1, 2, 2, 2, 2};
    int wi  [6] = '{0, 0, 0, 1, 2, 3};
    do_reset();
    en[2] = 4'hF;
    push(2, 0, wv(0, 0));
    push(2, 1, wv(1, 0));
    for (int j = 0; j < 4; j++) push(2, 2, wv(2, j));
    drive();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      look();
      if (i >= 1 && i <= 6) begin
        total++;
        if (o_v[2] !== 1'b1 || o_ch[2] !== 2'(seq[i-1]) || o_d[2] !== wv(seq[i-1], wi[i-1])) begin
          bad++;
          $display("FAIL release_seq step=%0d got v=%b ch=%0d d=%h required ch=%0d d=%h",
                   i - 1, o_v[2], o_ch[2], o_d[2], seq[i-1], wv(seq[i-1], wi[i-1]));
        end
      end else if (i == 7) begin
        total++;
        if (o_v[2] !== 1'b0) begin
          bad++;
          $display("FAIL release_end valid=%b required=0", o_v[2]);
        end
      end
      adv();
    end
  endtask

  task automatic test_masked_channels();
    int c;
    do_reset();
    en[0] = 4'b1010;
    for (int k = 0; k < N; k++)
      for (int j = 0; j < 4; j++) push(0, k, wv(k, j));
    drive();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      look();
      total++;
      if (o_en[0][0] !== 1'b0 || o_en[0][2] !== 1'b0) begin
        bad++;
        $display("FAIL masked_pop cyc=%0d got=%b required bits0,2=0", i, o_en[0]);
      end
      if (i >= 1 && i <= 8) begin
        c = (i % 2 == 1) ? 1 : 3;
        total++;
        if (o_v[0] !== 1'b1 || o_ch[0] !== 2'(c) || o_d[0] !== wv(c, (i - 1) / 2)) begin
          bad++;
          $display("FAIL masked_seq cyc=%0d got v=%b ch=%0d d=%h required ch=%0d d=%h",
                   i, o_v[0], o_ch[0], o_d[0], c, wv(c, (i - 1) / 2));
        end
      end else if (i == 9) begin
        total++;
        if (o_v[0] !== 1'b0) begin
          bad++;
          $display("FAIL masked_end valid=%b required=0", o_v[0]);
        end
      end
      adv();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en[1] = 4'hF;
    for (int c = 0; c < N; c++)
      for (int j = 0; j < 4; j++) push(1, c, wv(c, j));
    drive();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      look();
      if (i < 4) adv();
    end
    total++;
    if (o_v[1] !== 1'b1) begin
      bad++;
      $display("FAIL areset_pre valid=%b required=1", o_v[1]);
    end
    #2;
    rst = 1'b1;
    #1;
    snap();
    total++;
    if (o_v[1] !== 1'b0 || o_ch[1] !== 2'd0 || o_d[1] !== '0) begin
      bad++;
      $display("FAIL areset_clear got v=%b ch=%0d d=%h required 0/0/0", o_v[1], o_ch[1], o_d[1]);
    end
    total++;
    if (o_en[1] !== 4'b0000) begin
      bad++;
      $display("FAIL areset_pop got=%b required=0000", o_en[1]);
    end
    for (int k = 0; k < NK; k++) pe[k] = o_en[k];
    adv();
    en[1] = 4'hF;
    for (int c = 0; c < N; c++) push(1, c, wv(c, 10 + c));
    drive();
    rst = 1'b0;
    look();
    total++;
    if (o_en[1] !== 4'b0001) begin
      bad++;
      $display("FAIL areset_first_grant got=%b required=0001", o_en[1]);
    end
    adv();
    look();
    total++;
    if (o_v[1] !== 1'b1 || o_ch[1] !== 2'd0 || o_d[1] !== wv(0, 2)) begin
      bad++;
      $display("FAIL areset_first_word got v=%b ch=%0d d=%h required v=1 ch=0 d=%h",
               o_v[1], o_ch[1], o_d[1], wv(0, 2));
    end
    adv();
  endtask

  task automatic test_random();
    int           m_own [NK];
    int           m_cnt [NK];
    logic         m_v   [NK];
    logic [W-1:0] m_d   [NK];
    int           m_ch  [NK];
    do_reset();
    for (int k = 0; k < NK; k++) begin
      en[k]    = 4'hF;
      m_own[k] = N - 1;
      m_cnt[k] = mb_of(k);
      m_v[k]   = 1'b0;
      m_d[k]   = '0;
      m_ch[k]  = 0;
    end
    drive();
    rst = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      look();
      for (int k = 0; k < NK; k++) begin
        logic [N-1:0] req;
        logic [N-1:0] exp_en;
        logic         ld;
        bit           kept;
        int           g;
        req  = en[k] & ~empt(k);
        ld   = !m_v[k] || rdy[k];
        g    = -1;
        kept = 0;
        if (ld && req != '0) begin
          if (req[m_own[k]] && m_cnt[k] < mb_of(k)) begin
            g    = m_own[k];
            kept = 1;
          end else begin
            for (int s = 1; s <= N; s++)
              if (g < 0 && req[(m_own[k] + s) % N]) g = (m_own[k] + s) % N;
          end
        end
        exp_en = '0;
        if (g >= 0) exp_en[g] = 1'b1;
        total++;
        if (o_en[k] !== exp_en) begin
          bad++;
          $display("FAIL rand_pop k=%0d cyc=%0d got=%b required=%b", k, cyc, o_en[k], exp_en);
        end
        total++;
        if (o_v[k] !== m_v[k]) begin
          bad++;
          $display("FAIL rand_valid k=%0d cyc=%0d got=%b required=%b", k, cyc, o_v[k], m_v[k]);
        end
        if (m_v[k]) begin
          total++;
          if (o_d[k] !== m_d[k] || o_ch[k] !== 2'(m_ch[k])) begin
            bad++;
            $display("FAIL rand_data k=%0d cyc=%0d got ch=%0d d=%h required ch=%0d d=%h",
                     k, cyc, o_ch[k], o_d[k], m_ch[k], m_d[k]);
          end
        end
        if (ld) begin
          if (g >= 0) begin
            m_cnt[k] = kept ? m_cnt[k] + 1 : 1;
            m_own[k] = g;
            m_v[k]   = 1'b1;
            m_d[k]   = head(k, g);
            m_ch[k]  = g;
          end else begin
            m_v[k]   = 1'b0;
            m_cnt[k] = mb_of(k);
          end
        end
      end
      adv();
      for (int k = 0; k < NK; k++) begin
        rdy[k] = ($urandom % 4) != 0;
        if ($urandom % 8 == 0) en[k] = ($urandom % 3 == 0) ? 4'($urandom) : 4'hF;
        for (int c = 0; c < N; c++)
          if ($urandom % 3 == 0 && wrp[k][c] - rdp[k][c] < DEPTH - 2) push(k, c, 32'($urandom));
      end
      drive();
    end
  endtask

  initial begin
    test_reset();
    test_burst_rotation();
    test_backpressure();
    test_early_release();
    test_masked_channels();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
